// File: rtl/vga_fb_pkg.sv
// Shared constants and port-op encoding for the VGA framebuffer arbiter.
// Geometry is fixed at 640x480; the address math in fb_addr_calc relies on it.
package vga_fb_pkg;

    localparam logic [9:0]  H_ACTIVE  = 10'd640;
    localparam logic [9:0]  V_ACTIVE  = 10'd480;
    localparam int          FB_ADDR_W = 19;
    localparam int          FB_DATA_W = 8;
    localparam logic [18:0] FB_DEPTH  = 19'd307200;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } port_op_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer valid/ready bus into the framebuffer arbiter.
// The writer side is the master; the arbiter is the slave and drives wr_ready.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/fb_addr_calc.sv
// Linear framebuffer address y*640 + x built from shifts and adds, plus an
// in-range flag that marks the visible area.
module fb_addr_calc
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    // 640 = 512 + 128, so the multiply collapses to two shifted copies of y.
    assign addr     = (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
    assign in_range = (x < H_ACTIVE) && (y < V_ACTIVE);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch has priority, the writer gets the rest.
// Optional writer stall counter is built only when FB_STALL_CNT_EN is defined.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    input  logic [9:0]        x_pos,
    input  logic [9:0]        y_pos,
    vga_fb_arbiter_if.slave   wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic [15:0]       stall_cnt
);

    logic [9:0]        x_q;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_active;
    logic              x_evt;
    logic              disp_slot;
    logic              wr_fire;
    port_op_t          op_q, op_next;
    logic [ADDR_W-1:0] addr_next;
    logic              we_next;
    logic [DATA_W-1:0] wdata_next;
    logic              evt_d1, evt_d2, act_d2;

    fb_addr_calc #(.ADDR_W(ADDR_W)) u_addr_calc (
        .x        (x_pos),
        .y        (y_pos),
        .addr     (disp_addr),
        .in_range (disp_active)
    );

    // A pixel boundary is any cycle where x_pos differs from last cycle's copy.
    assign x_evt       = (x_pos != x_q);
    assign disp_slot   = disp_active && x_evt;
    assign wr.wr_ready = rst_n && !disp_slot;
    assign wr_fire     = wr.wr_valid && wr.wr_ready;

    always_comb begin
        op_next    = OP_IDLE;
        addr_next  = ram_addr;
        we_next    = 1'b0;
        wdata_next = ram_wdata;
        if (disp_slot) begin
            op_next   = OP_READ;
            addr_next = disp_addr;
        end else if (wr_fire) begin
            op_next    = OP_WRITE;
            addr_next  = wr.wr_addr;
            wdata_next = wr.wr_data;
            we_next    = (wr.wr_addr < ADDR_W'(FB_DEPTH));
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_IDLE;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            x_q       <= '0;
        end else begin
            op_q      <= op_next;
            ram_addr  <= addr_next;
            ram_we    <= we_next;
            ram_wdata <= wdata_next;
            x_q       <= x_pos;
        end
    end

    // Blanked boundaries travel the same pipeline so pixels and blanks share latency.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            evt_d1    <= 1'b0;
            evt_d2    <= 1'b0;
            act_d2    <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
        end else begin
            evt_d1 <= x_evt;
            evt_d2 <= evt_d1;
            act_d2 <= (op_q == OP_READ);
            if (evt_d2) begin
                pix_data  <= act_d2 ? ram_rdata : '0;
                pix_valid <= act_d2;
            end
        end
    end

`ifdef FB_STALL_CNT_EN
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (wr.wr_valid && !wr.wr_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a behavioural synchronous RAM.
// Expected stall count follows FB_STALL_CNT_EN.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    logic        clk_50MHz;
    logic        rst_n;
    logic [9:0]  x_pos, y_pos;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [15:0] stall_cnt;

    logic [7:0]  mem [0:(1<<19)-1];
    int          we_total;
    int          checks;
    int          errors;

    vga_fb_arbiter_if #(.ADDR_W(19), .DATA_W(8)) wr_bus ();

    vga_fb_arbiter #(.ADDR_W(19), .DATA_W(8)) dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .wr        (wr_bus.slave),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .stall_cnt (stall_cnt)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial we_total = 0;
    always @(posedge clk_50MHz) begin
        if (ram_we) we_total <= we_total + 1;
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 3 + 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [18:0] addr, input logic [7:0] data);
        wr_bus.wr_valid = valid;
        wr_bus.wr_addr  = addr;
        wr_bus.wr_data  = data;
    endtask

    task automatic waitCycle();
        @(posedge clk_50MHz);
        #1;
    endtask

    initial begin
        int  k, rdy_err, rd_cnt, wr_act, wr_bad, pix_err, pv_cnt, we_before;
        logic hs;
        logic [7:0] exp_pix;
        logic exp_pv;
        checks = 0;
        errors = 0;

        // Reset held with a pending writer request.
        rst_n = 1'b0;
        x_pos = 10'd0;
        y_pos = 10'd500;
        applyStimulus(1'b1, 19'd5, 8'h33);
        repeat (3) waitCycle();
        checkOutput("rst ram_addr", ram_addr, 0);
        checkOutput("rst ram_we", ram_we, 0);
        checkOutput("rst ram_wdata", ram_wdata, 0);
        checkOutput("rst pix_data", pix_data, 0);
        checkOutput("rst pix_valid", pix_valid, 0);
        checkOutput("rst stall_cnt", stall_cnt, 0);
        checkOutput("rst wr_ready", wr_bus.wr_ready, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("release wr_ready", wr_bus.wr_ready, 1);
        applyStimulus(1'b0, 19'd0, 8'h00);

        // Back-to-back writes during blanking.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 19'(10 + i), 8'(8'h11 + i));
            waitCycle();
            checkOutput($sformatf("b2b we %0d", i), ram_we, 1);
            checkOutput($sformatf("b2b addr %0d", i), ram_addr, 10 + i);
            checkOutput($sformatf("b2b data %0d", i), ram_wdata, 8'h11 + i);
        end
        applyStimulus(1'b0, 19'd0, 8'h00);
        waitCycle();
        checkOutput("b2b idle we", ram_we, 0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("b2b mem %0d", i), mem[10 + i], 8'h11 + i);

        // Out-of-range write is accepted but dropped.
        we_before = we_total;
        applyStimulus(1'b1, 19'd307200, 8'h77);
        checkOutput("oor wr_ready", wr_bus.wr_ready, 1);
        waitCycle();
        applyStimulus(1'b0, 19'd0, 8'h00);
        checkOutput("oor ram_we", ram_we, 0);
        waitCycle();
        checkOutput("oor no write pulses", we_total - we_before, 0);

        // Single fetch of RAM[641] at (1,1).
        applyStimulus(1'b1, 19'd641, 8'hA5);
        waitCycle();
        applyStimulus(1'b0, 19'd0, 8'h00);
        waitCycle();
        y_pos = 10'd1;
        waitCycle();
        x_pos = 10'd1;
        #1;
        checkOutput("fetch wr_ready", wr_bus.wr_ready, 0);
        waitCycle();
        checkOutput("fetch ram_addr", ram_addr, 641);
        checkOutput("fetch ram_we", ram_we, 0);
        waitCycle();
        checkOutput("fetch pix_valid early", pix_valid, 0);
        waitCycle();
        checkOutput("fetch pix_data", pix_data, 8'hA5);
        checkOutput("fetch pix_valid", pix_valid, 1);

        // Preload row 2 through the writer in blanking.
        y_pos = 10'd500;
        for (int i = 0; i < 640; i++) begin
            applyStimulus(1'b1, 19'(1280 + i), pat(i));
            waitCycle();
        end
        applyStimulus(1'b0, 19'd0, 8'h00);
        waitCycle();

        // Active line 2 with the writer saturating the port.
        y_pos = 10'd2;
        x_pos = 10'd799;
        waitCycle();
        waitCycle();
        k = 0; rdy_err = 0; rd_cnt = 0; wr_act = 0; wr_bad = 0; pix_err = 0; pv_cnt = 0;
        applyStimulus(1'b1, 19'd20000, 8'h00);
        for (int x = 0; x < 644; x++) begin
            x_pos = 10'(x);
            #1;
            if (wr_bus.wr_ready !== ((x < 640) ? 1'b0 : 1'b1)) rdy_err++;
            hs = wr_bus.wr_valid && wr_bus.wr_ready;
            waitCycle();
            if (x < 640 && ram_we === 1'b0 && ram_addr === 19'(1280 + x)) rd_cnt++;
            if (hs) begin
                if (ram_we === 1'b1 && ram_addr === 19'(20000 + k) && ram_wdata === 8'(k)) begin
                    if (x < 640) wr_act++;
                end else wr_bad++;
                k++;
                applyStimulus(1'b1, 19'(20000 + k), 8'(k));
            end
            #1;
            if (wr_bus.wr_ready !== 1'b1) rdy_err++;
            hs = wr_bus.wr_valid && wr_bus.wr_ready;
            if (x >= 1) begin
                exp_pv  = (x - 1) < 640;
                exp_pix = exp_pv ? pat(x - 1) : 8'h00;
                if (pix_valid !== exp_pv || pix_data !== exp_pix) pix_err++;
                if (pix_valid === 1'b1) pv_cnt++;
            end
            waitCycle();
            if (hs) begin
                if (ram_we === 1'b1 && ram_addr === 19'(20000 + k) && ram_wdata === 8'(k)) begin
                    if (x < 640) wr_act++;
                end else wr_bad++;
                k++;
                applyStimulus(1'b1, 19'(20000 + k), 8'(k));
            end
        end
        applyStimulus(1'b0, 19'd0, 8'h00);
        waitCycle();
        checkOutput("line ready pattern errs", rdy_err, 0);
        checkOutput("line reads", rd_cnt, 640);
        checkOutput("line active writes", wr_act, 640);
        checkOutput("line write errs", wr_bad, 0);
        checkOutput("line pixel errs", pix_err, 0);
        checkOutput("line pixel valid cnt", pv_cnt, 640);
`ifdef FB_STALL_CNT_EN
        checkOutput("line stall_cnt", stall_cnt, 640);
`else
        checkOutput("line stall_cnt", stall_cnt, 0);
`endif

        // Reset asserted while a write is on the RAM port.
        y_pos = 10'd500;
        applyStimulus(1'b1, 19'd50, 8'h99);
        waitCycle();
        checkOutput("midrst pre ram_we", ram_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst ram_we", ram_we, 0);
        checkOutput("midrst ram_addr", ram_addr, 0);
        checkOutput("midrst stall_cnt", stall_cnt, 0);
        checkOutput("midrst wr_ready", wr_bus.wr_ready, 0);
        applyStimulus(1'b0, 19'd0, 8'h00);
        waitCycle();
        rst_n = 1'b1;
        waitCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
